// File: rtl/load_store_unit.sv
// load_store_unit: MEM-stage load/store unit; define MISALIGN_SPLIT_EN to split misaligned
// accesses into aligned memory operations, otherwise they raise misalign_exc.
module load_store_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [6:0]  opcode,
    input  logic [2:0]  func3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        rvalid,
    output logic        misalign_exc,
    output logic        mem_read,
    output logic        mem_write,
    output logic [6:0]  mem_opcode,
    output logic [2:0]  mem_func3,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_dataW,
    input  logic [31:0] mem_dataR
);
`ifdef MISALIGN_SPLIT_EN
    localparam logic SPLIT = 1'b1;
`else
    localparam logic SPLIT = 1'b0;
`endif
    typedef enum logic [1:0] {IDLE, LD_HI, ST_BYTE} state_t;
    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d, lo_q, lo_d, data_q, data_d;
    logic [2:0]  f3_q, f3_d, n_q, n_d;
    logic [1:0]  off_q, off_d, i_q, i_d;
    logic        is_ld, is_st, half, word, misal;
    logic [31:0] shifted;
    always_comb begin
        is_ld = req_valid && opcode == 7'd3;
        is_st = req_valid && opcode == 7'd35;
        half  = func3 == 3'd1 || (is_ld && func3 == 3'd5);
        word  = func3 == 3'd2;
        misal = (is_ld || is_st) && ((half && addr[0]) || (word && addr[1:0] != 2'b00));
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            lo_q    <= '0;
            data_q  <= '0;
            f3_q    <= '0;
            n_q     <= '0;
            off_q   <= '0;
            i_q     <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            lo_q    <= lo_d;
            data_q  <= data_d;
            f3_q    <= f3_d;
            n_q     <= n_d;
            off_q   <= off_d;
            i_q     <= i_d;
        end
    end
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        lo_d    = lo_q;
        data_d  = data_q;
        f3_d    = f3_q;
        n_d     = n_q;
        off_d   = off_q;
        i_d     = i_q;
        case (state_q)
            IDLE: if (SPLIT && misal) begin
                state_d = is_ld ? LD_HI : ST_BYTE;
                addr_d  = is_ld ? {addr[31:2], 2'b00} : addr;
                lo_d    = mem_dataR;
                data_d  = wdata;
                f3_d    = func3;
                off_d   = addr[1:0];
                n_d     = word ? 3'd4 : 3'd2;
                i_d     = 2'd1;
            end
            LD_HI: state_d = IDLE;
            ST_BYTE: begin
                i_d     = i_q + 2'd1;
                state_d = ({1'b0, i_q} == n_q - 3'd1) ? IDLE : ST_BYTE;
            end
            default: state_d = IDLE;
        endcase
    end
    // The low word was captured last cycle; the high word arrives now.
    assign shifted = 32'({mem_dataR, lo_q} >> {off_q, 3'b000});
    always_comb begin
        stall        = 1'b0;
        rdata        = '0;
        rvalid       = 1'b0;
        misalign_exc = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        mem_opcode   = rst ? 7'd0 : opcode;
        mem_func3    = rst ? 3'd0 : func3;
        mem_addr     = rst ? 32'd0 : addr;
        mem_dataW    = rst ? 32'd0 : wdata;
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    if (misal && !SPLIT) begin
                        misalign_exc = 1'b1;
                    end else if (misal) begin
                        stall     = 1'b1;
                        mem_read  = is_ld;
                        mem_write = is_st;
                        mem_func3 = is_ld ? 3'd2 : 3'd0;
                        mem_addr  = is_ld ? {addr[31:2], 2'b00} : addr;
                        mem_dataW = {24'h0, wdata[7:0]};
                    end else begin
                        mem_read  = is_ld;
                        mem_write = is_st;
                        rvalid    = is_ld;
                        rdata     = is_ld ? mem_dataR : 32'd0;
                    end
                end
                LD_HI: begin
                    mem_read   = 1'b1;
                    rvalid     = 1'b1;
                    mem_opcode = 7'd3;
                    mem_func3  = 3'd2;
                    mem_addr   = addr_q + 32'd4;
                    rdata      = f3_q == 3'd2 ? shifted :
                                 f3_q == 3'd1 ? {{16{shifted[15]}}, shifted[15:0]} :
                                                {16'h0, shifted[15:0]};
                end
                ST_BYTE: begin
                    mem_write  = 1'b1;
                    mem_opcode = 7'd35;
                    mem_func3  = 3'd0;
                    mem_addr   = addr_q + {30'd0, i_q};
                    mem_dataW  = {24'h0, 8'(data_q >> {i_q, 3'b000})};
                    stall      = {1'b0, i_q} != n_q - 3'd1;
                end
                default: ;
            endcase
        end
    end
endmodule
